// File: rtl/alu_pkg.sv
// alu_pkg: shared width and function-code constants for the registered ALU
package alu_pkg;
  localparam int W = 32;
  localparam logic [5:0] FN_HOLD = 6'b000000;
  localparam logic [5:0] FN_ADD  = 6'b000001;
  localparam logic [5:0] FN_SUB  = 6'b000010;
  localparam logic [5:0] FN_AND  = 6'b000011;
  localparam logic [5:0] FN_OR   = 6'b000100;
  localparam logic [5:0] FN_XOR  = 6'b000101;
  localparam logic [5:0] FN_NOR  = 6'b000110;
  localparam logic [5:0] FN_SLT  = 6'b000111;
  localparam logic [5:0] FN_SLL  = 6'b001000;
  localparam logic [5:0] FN_SRL  = 6'b001001;
  localparam logic [5:0] FN_SRA  = 6'b001010;
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational barrel shifter for SLL/SRL/SRA
//   a     - value to shift
//   amt   - shift amount (0 passes a through)
//   funct - selects SLL, SRL or SRA (anything else behaves as SRA)
//   y     - shifted result
module alu_shifter
  import alu_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [4:0]   amt,
  input  logic [5:0]   funct,
  output logic [W-1:0] y
);
  always_comb begin
    y = funct == FN_SLL ? a << amt :
        funct == FN_SRL ? a >> amt :
        W'($signed(a) >>> amt);
  end
endmodule

// File: rtl/alu.sv
// alu: registered 32-bit ALU with carry/borrow flag and hold code
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears Result and Carry
//   Src_1  - operand A
//   Src_2  - operand B; low 5 bits are the shift amount
//   Funct  - operation code (see alu_pkg)
//   Result - registered result
//   Carry  - registered carry (ADD) or borrow (SUB) flag
// Build option ALU_SHIFT_EN: when defined, SLL/SRL/SRA use alu_shifter;
// otherwise those codes are treated as unmapped and clear the outputs.
module alu
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] Src_1,
  input  logic [W-1:0] Src_2,
  input  logic [5:0]   Funct,
  output logic [W-1:0] Result,
  output logic         Carry
);
  logic [W:0]   sum;
  logic [W:0]   diff;
  logic [W-1:0] sh_y;
  logic [W-1:0] nxt_res;
  logic         nxt_c;
  assign sum  = {1'b0, Src_1} + {1'b0, Src_2};
  // bit W of the 33-bit difference is the unsigned borrow
  assign diff = {1'b0, Src_1} - {1'b0, Src_2};
`ifdef ALU_SHIFT_EN
  alu_shifter u_shifter (
    .a     (Src_1),
    .amt   (Src_2[4:0]),
    .funct (Funct),
    .y     (sh_y)
  );
`else
  assign sh_y = '0;
`endif
  always_comb begin
    nxt_res = '0;
    nxt_c   = 1'b0;
    case (Funct)
      FN_ADD: {nxt_c, nxt_res} = sum;
      FN_SUB: {nxt_c, nxt_res} = diff;
      FN_AND: nxt_res = Src_1 & Src_2;
      FN_OR:  nxt_res = Src_1 | Src_2;
      FN_XOR: nxt_res = Src_1 ^ Src_2;
      FN_NOR: nxt_res = ~(Src_1 | Src_2);
      FN_SLT: nxt_res = {{(W-1){1'b0}}, $signed(Src_1) < $signed(Src_2)};
      FN_SLL, FN_SRL, FN_SRA: nxt_res = sh_y;
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Result <= '0;
      Carry  <= 1'b0;
    end else if (Funct != FN_HOLD) begin
      Result <= nxt_res;
      Carry  <= nxt_c;
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu
module tb_alu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Src_1 = '0;
  logic [31:0] Src_2 = '0;
  logic [5:0]  Funct = '0;
  logic [31:0] Result;
  logic        Carry;
  int n_chk = 0;
  int n_err = 0;
`ifdef ALU_SHIFT_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif
  alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Src_1  (Src_1),
    .Src_2  (Src_2),
    .Funct  (Funct),
    .Result (Result),
    .Carry  (Carry)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got carry=%0b result=%08h, expected carry=%0b result=%08h",
               tag, got[32], got[31:0], exp[32], exp[31:0]);
    end
  endtask
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    Src_1 = a;
    Src_2 = b;
    Funct = f;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    check("reset_state", {Carry, Result}, 33'h0);
    #10;
    rst_n = 1'b1;
    op(32'h00000001, 32'h00000002, 6'h01); check("add_nc", {Carry, Result}, {1'b0, 32'h00000003});
    op(32'hFFFFFFFF, 32'h00000001, 6'h01); check("add_c", {Carry, Result}, {1'b1, 32'h00000000});
    for (int i = 0; i < 3; i++) begin
      op(32'h12345678, 32'h9ABCDEF0, 6'h00); check("hold", {Carry, Result}, {1'b1, 32'h00000000});
    end
    op(32'h12345678, 32'h9ABCDEF0, 6'h3F); check("unmapped_3f", {Carry, Result}, 33'h0);
    op(32'h00000001, 32'h00000002, 6'h02); check("sub_borrow", {Carry, Result}, {1'b1, 32'hFFFFFFFF});
    op(32'h00000005, 32'h00000003, 6'h02); check("sub_nb", {Carry, Result}, {1'b0, 32'h00000002});
    op(32'h00000007, 32'h00000007, 6'h02); check("sub_eq", {Carry, Result}, {1'b0, 32'h00000000});
    op(32'hFFFFFFFF, 32'h00000001, 6'h01); check("add_c2", {Carry, Result}, {1'b1, 32'h00000000});
    op(32'hF0F0F0F0, 32'hFF00FF00, 6'h03); check("and", {Carry, Result}, {1'b0, 32'hF000F000});
    op(32'hF0F0F0F0, 32'hFF00FF00, 6'h04); check("or", {Carry, Result}, {1'b0, 32'hFFF0FFF0});
    op(32'hF0F0F0F0, 32'hFF00FF00, 6'h05); check("xor", {Carry, Result}, {1'b0, 32'h0FF00FF0});
    op(32'hF0F0F0F0, 32'hFF00FF00, 6'h06); check("nor", {Carry, Result}, {1'b0, 32'h000F000F});
    op(32'hFFFFFFFF, 32'h00000001, 6'h07); check("slt_neg", {Carry, Result}, {1'b0, 32'h00000001});
    op(32'h00000001, 32'hFFFFFFFF, 6'h07); check("slt_pos", {Carry, Result}, {1'b0, 32'h00000000});
    op(32'h00000003, 32'h00000003, 6'h07); check("slt_eq", {Carry, Result}, {1'b0, 32'h00000000});
    op(32'h80000000, 32'h00000004, 6'h0A); check("sra", {Carry, Result}, {1'b0, SH ? 32'hF8000000 : 32'h0});
    op(32'h40000000, 32'h00000004, 6'h0A); check("sra_pos", {Carry, Result}, {1'b0, SH ? 32'h04000000 : 32'h0});
    op(32'h00000001, 32'h0000001F, 6'h08); check("sll31", {Carry, Result}, {1'b0, SH ? 32'h80000000 : 32'h0});
    op(32'h80000000, 32'h0000001F, 6'h09); check("srl31", {Carry, Result}, {1'b0, SH ? 32'h00000001 : 32'h0});
    op(32'h80000000, 32'hFFFFFFE4, 6'h09); check("srl_amt_mask", {Carry, Result}, {1'b0, SH ? 32'h08000000 : 32'h0});
    op(32'hA5A5A5A5, 32'h00000000, 6'h08); check("sll0", {Carry, Result}, {1'b0, SH ? 32'hA5A5A5A5 : 32'h0});
    op(32'h12345678, 32'h00000001, 6'h0B); check("unmapped_0b", {Carry, Result}, 33'h0);
    op(32'hFFFFFFFF, 32'h00000001, 6'h01);
    op(32'h00000001, 32'h00000002, 6'h01); check("pre_reset", {Carry, Result}, {1'b0, 32'h00000003});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {Carry, Result}, 33'h0);
    op(32'hFFFFFFFF, 32'h00000001, 6'h01); check("reset_over_clk", {Carry, Result}, 33'h0);
    op(32'h12345678, 32'h0, 6'h00); check("reset_over_hold", {Carry, Result}, 33'h0);
    #2;
    rst_n = 1'b1;
    op(32'hFFFFFFFF, 32'h00000002, 6'h01); check("first_after_reset", {Carry, Result}, {1'b1, 32'h00000001});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
